seg_status_hold: RTL and testbench
==================================

# seg_status_hold

Parametrised status encoder for the 7-segment display. It reduces memory-controller status and the buffered user inputs to `DIGITS` hex digits in a registered output. Unlike the single-cycle encoder, it latches memory errors and counts them, and it holds each displayed input index for a minimum time so short button presses stay readable. It sits between the input buffer/LPDDR status and the 7-segment scan driver.

## Interface
- `N_INPUTS`, 46: number of buffered user inputs; must be ≤ 10^(DIGITS-1).
- `DIGITS`, 3: number of hex digits driven; ≥ 2.
- `HOLD_CYCLES`, 50_000_000: minimum cycles an index stays displayed after it was last seen active; 0 disables hold.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_calib_done` in 1: high once LPDDR calibration is complete.
- `mem_error` in 1: LPDDR bit-error flag (level).
- `err_clear` in 1: single-cycle request to clear the latched error and its count.
- `buf_inputs` in N_INPUTS: buffered user inputs, already synchronous to `clk`.
- `seg_digits` out 4*DIGITS: registered display code. The most significant digit is the class and the lower DIGITS-1 digits are BCD.
- `seg_changed` out 1: one-cycle pulse when `seg_digits` takes a new value.

## Operation
- Class digit (MS nibble): 5 = memory fault, 1 = idle, 0 = input index shown. Lower digits form a BCD payload.
- States: UNCALIB, ERROR, IDLE, SHOW. Priority is UNCALIB > ERROR > SHOW/IDLE, evaluated every cycle.
- UNCALIB: entered whenever `mem_calib_done`=0. Output is class 5, payload 0 (DIGITS=3 gives 0x500). The hold counter and shown index are discarded.
- Error latch `err_q`:
  - Set on any cycle where `mem_error`=1 and `mem_calib_done`=1.
  - Cleared by `err_clear` only if `mem_error`=0 in the same cycle. If both are high, `err_q` stays set.
  - Not cleared by calibration loss.
- Error count:
  - Incremented on each rising edge of `mem_error` while calibrated.
  - Saturates at 10^(DIGITS-1)-1.
  - Zeroed by a successful clear.
- ERROR state: `err_q`=1 and calibrated. Output is class 5 with the BCD error count (first error gives 0x501).
- Lowest active index `lo` = smallest i with `buf_inputs[i]`=1 (priority encoder, lowest wins).
- IDLE: no active input and hold counter at 0. Output is class 1, payload 0 (0x100).
- Entering SHOW:
  - From IDLE with any input active: latch `lo` as `shown` and load the hold counter with HOLD_CYCLES.
- In SHOW:
  - If `lo` == `shown`, reload the counter.
  - Otherwise, decrement the counter if it is nonzero. When it is 0 and an input is active, latch the new `lo` and reload.
  - When it is 0 with no input active, go to IDLE.
  - Output is class 0 with BCD of `shown`.
- HOLD_CYCLES=0: `shown` follows `lo` every cycle (pure priority behaviour, one cycle late).
- On leaving ERROR via clear, go to IDLE. Resolve from IDLE on the next cycle.

## Timing
- Reset: state UNCALIB, `seg_digits` = class 5 / payload 0, `seg_changed`=0, `err_q`=0, count=0, hold counter=0, `shown`=0.
- Latency: one clock from input change to `seg_digits` update. `seg_changed` is asserted in the same cycle the new value appears.
- Hold: with input i pulsed for 1 cycle at cycle t, index i is displayed from t+1 through t+1+HOLD_CYCLES inclusive, then idle (or the next index).
- Counter width: clog2(HOLD_CYCLES+1). No wrap; it stops at 0.
- Reset mid-hold or mid-error returns everything to reset values immediately (asynchronous).

## Structure
- Package `seg_status_pkg` holds:
  - class nibble constants (CLASS_FAULT=5, CLASS_IDLE=1, CLASS_INDEX=0);
  - the state enum;
  - the function computing the BCD digit count.
- One sub-module, `bin2bcd`: combinational double-dabble with parameters for binary width and BCD digits. It has two instances, one for the shown index and one for the error count.

## Test plan
- Reset with `mem_calib_done`=0 → `seg_digits`=0x500. Raise calib with no inputs → 0x100 one cycle later, with a `seg_changed` pulse.
- DIGITS=3, HOLD_CYCLES=4: pulse `buf_inputs[13]` for 1 cycle → 0x013 for 5 cycles, then 0x100.
- `buf_inputs[2]` and `[11]` held together → 0x002. Drop [2] while holding [11] → 0x002 for 4 more cycles, then 0x011.
- Three `mem_error` pulses while an input is active → 0x501, 0x502, 0x503. Then:
  - `err_clear` with `mem_error` high → stays 0x503.
  - `err_clear` with `mem_error` low → 0x100, then the input index.
- 120 error edges with DIGITS=3 → count saturates, display 0x599.
- Drop `mem_calib_done` during SHOW → 0x500 next cycle. Restore it → 0x100, then the index; the hold counter is restarted.

Source files
------------

// File: rtl/seg_status_pkg.sv
// Shared constants, state type and sizing helpers for the 7-segment status encoder.
package seg_status_pkg;

  localparam logic [3:0] CLASS_FAULT = 4'h5;
  localparam logic [3:0] CLASS_IDLE  = 4'h1;
  localparam logic [3:0] CLASS_INDEX = 4'h0;

  typedef enum logic [1:0] {
    ST_UNCALIB,
    ST_ERROR,
    ST_IDLE,
    ST_SHOW
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Decimal digits needed to hold the largest value of a bin_w-bit number.
  function automatic int unsigned bcd_digits(input int unsigned bin_w);
    longint unsigned max_v;
    int unsigned     d;
    max_v = (64'd1 << bin_w) - 64'd1;
    d     = 1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Combinational double-dabble binary to packed-BCD converter.
module bin2bcd
  import seg_status_pkg::*;
#(
  parameter int unsigned BIN_W      = 8,
  parameter int unsigned BCD_DIGITS = bcd_digits(BIN_W)
) (
  input  logic [BIN_W-1:0]        bin,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  // Narrower BCD_DIGITS than the full range is safe as long as the value fits.
  always_comb begin
    logic [4*BCD_DIGITS-1:0] acc;
    logic [BIN_W-1:0]        sh;
    acc = '0;
    sh  = bin;
    for (int unsigned i = 0; i < BIN_W; i++) begin
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*BCD_DIGITS-2:0], sh[BIN_W-1]};
      sh  = sh << 1;
    end
    bcd = acc;
  end

endmodule

// File: rtl/seg_status_hold.sv
// Status encoder for the 7-segment display: memory fault latch/count plus
// a minimum-hold display of the lowest active user input index.
module seg_status_hold
  import seg_status_pkg::*;
#(
  parameter int unsigned N_INPUTS    = 46,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_calib_done,
  input  logic                  mem_error,
  input  logic                  err_clear,
  input  logic [N_INPUTS-1:0]   buf_inputs,
  output logic [4*DIGITS-1:0]   seg_digits,
  output logic                  seg_changed
);

  localparam int unsigned PAY_D   = DIGITS - 1;
  localparam int unsigned IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int unsigned CNT_MAX = pow10(PAY_D) - 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HOLD_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [4*PAY_D-1:0]  PAY_ZERO  = '0;
  localparam logic [4*DIGITS-1:0] SEG_RESET = {CLASS_FAULT, PAY_ZERO};

  state_t            state_q, state_n;
  logic              err_q, err_n, err_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [IDX_W-1:0]  shown_q, shown_n, lo;
  logic              any;
  logic              clr_ok, err_rise;
  logic [4*PAY_D-1:0]  idx_bcd, cnt_bcd;
  logic [4*DIGITS-1:0] seg_n;

  always_comb begin
    lo  = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (buf_inputs[i] && !any) begin
        lo  = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

  assign clr_ok   = err_clear && !mem_error;
  assign err_rise = mem_calib_done && mem_error && !err_prev_q;

  always_comb begin
    err_n = err_q;
    if (mem_calib_done && mem_error) err_n = 1'b1;
    else if (clr_ok)                 err_n = 1'b0;

    cnt_n = cnt_q;
    if (clr_ok)                            cnt_n = '0;
    else if (err_rise && cnt_q != CNT_SAT) cnt_n = cnt_q + 1'b1;
  end

  // Next state is built from next error status so outputs lag inputs by one clock.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    shown_n = shown_q;
    if (!mem_calib_done) begin
      state_n = ST_UNCALIB;
      hold_n  = '0;
      shown_n = '0;
    end else if (err_n) begin
      state_n = ST_ERROR;
      hold_n  = '0;
      shown_n = '0;
    end else begin
      case (state_q)
        ST_UNCALIB, ST_ERROR: state_n = ST_IDLE;
        ST_IDLE: begin
          if (any) begin
            state_n = ST_SHOW;
            shown_n = lo;
            hold_n  = HOLD_LOAD;
          end
        end
        ST_SHOW: begin
          if (any && lo == shown_q) begin
            hold_n = HOLD_LOAD;
          end else if (hold_q != '0) begin
            hold_n = hold_q - 1'b1;
          end else if (any) begin
            shown_n = lo;
            hold_n  = HOLD_LOAD;
          end else begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_UNCALIB;
      endcase
    end
  end

  bin2bcd #(.BIN_W(IDX_W), .BCD_DIGITS(PAY_D)) u_idx_bcd (.bin(shown_n), .bcd(idx_bcd));
  bin2bcd #(.BIN_W(CNT_W), .BCD_DIGITS(PAY_D)) u_cnt_bcd (.bin(cnt_n),   .bcd(cnt_bcd));

  always_comb begin
    seg_n = SEG_RESET;
    case (state_n)
      ST_UNCALIB: seg_n = {CLASS_FAULT, PAY_ZERO};
      ST_ERROR:   seg_n = {CLASS_FAULT, cnt_bcd};
      ST_IDLE:    seg_n = {CLASS_IDLE,  PAY_ZERO};
      ST_SHOW:    seg_n = {CLASS_INDEX, idx_bcd};
      default:    seg_n = SEG_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNCALIB;
      err_q       <= 1'b0;
      err_prev_q  <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
      shown_q     <= '0;
      seg_digits  <= SEG_RESET;
      seg_changed <= 1'b0;
    end else begin
      state_q     <= state_n;
      err_q       <= err_n;
      err_prev_q  <= mem_error;
      cnt_q       <= cnt_n;
      hold_q      <= hold_n;
      shown_q     <= shown_n;
      seg_digits  <= seg_n;
      seg_changed <= (seg_n != seg_digits);
    end
  end

endmodule

// File: tb/tb_seg_status_hold.sv
// Self-checking bench for seg_status_hold (DIGITS=3, HOLD_CYCLES=4).
module tb_seg_status_hold;

  localparam int N = 46;
  localparam int D = 3;
  localparam int H = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_calib_done = 1'b0;
  logic          mem_error = 1'b0;
  logic          err_clear = 1'b0;
  logic [N-1:0]  buf_inputs = '0;
  logic [11:0]   seg_digits;
  logic          seg_changed;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: timestamp-based hold, plain integer counters.
  int          m_cnt, m_shown, m_deadline, cyc;
  bit          m_err, m_prev, m_wait;
  logic [11:0] exp_seg, exp_prev;
  logic        exp_chg;

  seg_status_hold #(.N_INPUTS(N), .DIGITS(D), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .mem_calib_done(mem_calib_done), .mem_error(mem_error),
    .err_clear(err_clear), .buf_inputs(buf_inputs), .seg_digits(seg_digits),
    .seg_changed(seg_changed)
  );

  always #5 clk = ~clk;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_prev = 0; m_wait = 1;
    m_shown = -1; m_deadline = 0; cyc = 0;
    exp_seg = 12'h500; exp_prev = 12'h500; exp_chg = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic e, input logic k, input logic [N-1:0] b);
    int lo;
    cyc++;
    if (c && e && !m_prev && m_cnt < 99) m_cnt++;
    if (k && !e) m_cnt = 0;
    if (c && e) m_err = 1;
    else if (k && !e) m_err = 0;
    m_prev = e;
    lo = -1;
    for (int i = N - 1; i >= 0; i--) if (b[i]) lo = i;
    if (!c) begin
      exp_seg = 12'h500; m_shown = -1; m_wait = 1;
    end else if (m_err) begin
      exp_seg = 12'(32'h500 + to_bcd(m_cnt)); m_shown = -1; m_wait = 1;
    end else if (m_wait) begin
      exp_seg = 12'h100; m_wait = 0;
    end else begin
      if (m_shown < 0) begin
        if (lo >= 0) begin m_shown = lo; m_deadline = cyc + H; end
      end else if (lo == m_shown) begin
        m_deadline = cyc + H;
      end else if (cyc > m_deadline) begin
        m_shown = lo;
        if (lo >= 0) m_deadline = cyc + H;
      end
      exp_seg = (m_shown < 0) ? 12'h100 : 12'(to_bcd(m_shown));
    end
    exp_chg  = (exp_seg != exp_prev);
    exp_prev = exp_seg;
  endtask

  task automatic drive(input logic c, input logic e, input logic k, input logic [N-1:0] b);
    mem_calib_done = c; mem_error = e; err_clear = k; buf_inputs = b;
    @(posedge clk); #1;
    model_step(c, e, k, b);
  endtask

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (seg_digits !== 12'h500) begin n_fail++; $display("FAIL reset_seg: got %h want 500", seg_digits); end
    n_cmp++;
    if (seg_changed !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %b want 0", seg_changed); end
    rst = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h500 || seg_changed !== 1'b0)
      begin n_fail++; $display("FAIL uncalib_hold: got %h/%b want 500/0", seg_digits, seg_changed); end
  endtask

  task automatic test_calib_up();
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h100 || seg_changed !== 1'b1)
      begin n_fail++; $display("FAIL calib_up: got %h/%b want 100/1", seg_digits, seg_changed); end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_changed !== 1'b0) begin n_fail++; $display("FAIL calib_steady_chg: got %b want 0", seg_changed); end
  endtask

  task automatic test_hold_pulse();
    drive(1'b1, 1'b0, 1'b0, bit_at(13));
    n_cmp++;
    if (seg_digits !== 12'h013 || seg_changed !== 1'b1)
      begin n_fail++; $display("FAIL pulse_first: got %h/%b want 013/1", seg_digits, seg_changed); end
    for (int k = 0; k < H; k++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      n_cmp++;
      if (seg_digits !== 12'h013) begin n_fail++; $display("FAIL pulse_hold[%0d]: got %h want 013", k, seg_digits); end
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h100 || seg_changed !== 1'b1)
      begin n_fail++; $display("FAIL pulse_expire: got %h/%b want 100/1", seg_digits, seg_changed); end
  endtask

  task automatic test_overlap();
    logic [N-1:0] both;
    both = bit_at(2) | bit_at(11);
    drive(1'b1, 1'b0, 1'b0, both);
    drive(1'b1, 1'b0, 1'b0, both);
    n_cmp++;
    if (seg_digits !== 12'h002) begin n_fail++; $display("FAIL overlap_lowest: got %h want 002", seg_digits); end
    for (int k = 0; k < H; k++) begin
      drive(1'b1, 1'b0, 1'b0, bit_at(11));
      n_cmp++;
      if (seg_digits !== 12'h002) begin n_fail++; $display("FAIL overlap_hold[%0d]: got %h want 002", k, seg_digits); end
    end
    drive(1'b1, 1'b0, 1'b0, bit_at(11));
    n_cmp++;
    if (seg_digits !== 12'h011) begin n_fail++; $display("FAIL overlap_switch: got %h want 011", seg_digits); end
    repeat (H + 1) drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h100) begin n_fail++; $display("FAIL overlap_idle: got %h want 100", seg_digits); end
  endtask

  task automatic test_errors();
    logic [N-1:0] b7;
    b7 = bit_at(7);
    drive(1'b1, 1'b0, 1'b0, b7);
    n_cmp++;
    if (seg_digits !== 12'h007) begin n_fail++; $display("FAIL err_pre_show: got %h want 007", seg_digits); end
    for (int p = 1; p <= 3; p++) begin
      drive(1'b1, 1'b1, 1'b0, b7);
      n_cmp++;
      if (seg_digits !== 12'(32'h500 + p)) begin n_fail++; $display("FAIL err_count[%0d]: got %h want %h", p, seg_digits, 12'(32'h500 + p)); end
      if (p < 3) drive(1'b1, 1'b0, 1'b0, b7);
    end
    drive(1'b1, 1'b1, 1'b1, b7);
    n_cmp++;
    if (seg_digits !== 12'h503) begin n_fail++; $display("FAIL err_clear_blocked: got %h want 503", seg_digits); end
    drive(1'b1, 1'b0, 1'b1, b7);
    n_cmp++;
    if (seg_digits !== 12'h100) begin n_fail++; $display("FAIL err_clear_ok: got %h want 100", seg_digits); end
    drive(1'b1, 1'b0, 1'b0, b7);
    n_cmp++;
    if (seg_digits !== 12'h007) begin n_fail++; $display("FAIL err_resume: got %h want 007", seg_digits); end
  endtask

  task automatic test_saturate();
    logic [N-1:0] b7;
    b7 = bit_at(7);
    for (int p = 0; p < 120; p++) begin
      drive(1'b1, 1'b1, 1'b0, b7);
      drive(1'b1, 1'b0, 1'b0, b7);
    end
    n_cmp++;
    if (seg_digits !== 12'h599) begin n_fail++; $display("FAIL saturate: got %h want 599", seg_digits); end
    drive(1'b1, 1'b0, 1'b1, b7);
    drive(1'b1, 1'b1, 1'b0, b7);
    n_cmp++;
    if (seg_digits !== 12'h501) begin n_fail++; $display("FAIL count_after_clear: got %h want 501", seg_digits); end
    drive(1'b1, 1'b0, 1'b1, b7);
    drive(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic test_calib_drop();
    logic [N-1:0] b5;
    b5 = bit_at(5);
    repeat (H + 2) drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, b5);
    drive(1'b1, 1'b0, 1'b0, b5);
    n_cmp++;
    if (seg_digits !== 12'h005) begin n_fail++; $display("FAIL drop_pre: got %h want 005", seg_digits); end
    drive(1'b0, 1'b0, 1'b0, b5);
    n_cmp++;
    if (seg_digits !== 12'h500) begin n_fail++; $display("FAIL drop_uncalib: got %h want 500", seg_digits); end
    drive(1'b1, 1'b0, 1'b0, b5);
    n_cmp++;
    if (seg_digits !== 12'h100) begin n_fail++; $display("FAIL drop_restore: got %h want 100", seg_digits); end
    drive(1'b1, 1'b0, 1'b0, b5);
    n_cmp++;
    if (seg_digits !== 12'h005) begin n_fail++; $display("FAIL drop_reshow: got %h want 005", seg_digits); end
    for (int k = 0; k < H; k++) begin
      drive(1'b1, 1'b0, 1'b0, '0);
      n_cmp++;
      if (seg_digits !== 12'h005) begin n_fail++; $display("FAIL drop_rehold[%0d]: got %h want 005", k, seg_digits); end
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h100) begin n_fail++; $display("FAIL drop_expire: got %h want 100", seg_digits); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 1'b0, bit_at(9));
    drive(1'b1, 1'b0, 1'b0, bit_at(9));
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg_digits !== 12'h500 || seg_changed !== 1'b0)
      begin n_fail++; $display("FAIL async_reset: got %h/%b want 500/0", seg_digits, seg_changed); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    n_cmp++;
    if (seg_digits !== 12'h100) begin n_fail++; $display("FAIL async_reset_errq: got %h want 100", seg_digits); end
  endtask

  task automatic test_random();
    logic         c, e, k;
    logic [N-1:0] b;
    c = 1'b1; e = 1'b0; b = '0;
    for (int t = 0; t < 3000; t++) begin
      c = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 9) == 0) e = ~e;
      k = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 3) begin
        b = '0;
        if ($urandom_range(0, 1) == 1) b[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 3) == 0) b[$urandom_range(0, N - 1)] = 1'b1;
      end
      drive(c, e, k, b);
      n_cmp++;
      if (seg_digits !== exp_seg || seg_changed !== exp_chg)
        begin n_fail++; $display("FAIL random[%0d]: got %h/%b want %h/%b", t, seg_digits, seg_changed, exp_seg, exp_chg); end
    end
  endtask

  initial begin
    test_reset();
    test_calib_up();
    test_hold_pulse();
    test_overlap();
    test_errors();
    test_saturate();
    test_calib_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
